router_input_fifo: RTL and testbench

Input buffer for one router port. It sits directly downstream of a neighbouring router's output arbiter on the inter-router link and upstream of this router's five output arbiters. It accepts flits over the RTS/CTS link handshake, stores up to DEPTH flits, and presents the head flit first-word-fall-through. The head flit is popped when any output arbiter grants this port.

---
 rtl/router_input_fifo.sv | 76 +++++++
 tb/tb_router_input_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/router_input_fifo.sv
// Router input buffer: RTS/CTS link receiver feeding a first-word-fall-through flit FIFO.
// Write-to-Data_out latency 1 cycle; CTS is withheld while full, stalling upstream with RTS held.
module router_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   RX,
    input  logic                    DRTS,
    input  logic                    read_en_N,
    input  logic                    read_en_E,
    input  logic                    read_en_W,
    input  logic                    read_en_S,
    input  logic                    read_en_L,
    output logic                    CTS,
    output logic [DATA_WIDTH-1:0]   Data_out,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err_overflow,
    output logic                    err_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  read_req;
    logic                  read_do;
    logic                  write_en;

    // Several arbiters granting in the same cycle still pop a single flit.
    assign read_req = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign write_en = DRTS & CTS & ~full;
    assign read_do  = read_req & ~empty;
    assign Data_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            CTS           <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // One-cycle CTS pulse per flit: never reasserted on the cycle after it was high.
            CTS <= DRTS & ~CTS & ~full;
            if (write_en) begin
                mem[wr_ptr] <= RX;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (read_do) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (write_en && !read_do) begin
                count <= count + (AW+1)'(1);
            end else if (!write_en && read_do) begin
                count <= count - (AW+1)'(1);
            end
            if (DRTS && CTS && full) begin
                err_overflow <= 1'b1;
            end
            if (read_req && empty) begin
                err_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_router_input_fifo.sv
// Bench for router_input_fifo: directed scenarios plus random traffic against a queue model.
module tb_router_input_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DRTS = 1'b0;
    logic [DW-1:0] RX = '0;
    logic          rN = 1'b0, rE = 1'b0, rW = 1'b0, rS = 1'b0, rL = 1'b0;
    logic          CTS;
    logic [DW-1:0] Data_out;
    logic          empty, full;
    logic [2:0]    count;
    logic          err_overflow, err_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: flit queue plus link handshake and sticky flags.
    logic [DW-1:0] m_q[$];
    bit            m_cts = 0, m_ovf = 0, m_unf = 0, m_wrote = 0;

    router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .RX(RX), .DRTS(DRTS),
        .read_en_N(rN), .read_en_E(rE), .read_en_W(rW), .read_en_S(rS), .read_en_L(rL),
        .CTS(CTS), .Data_out(Data_out), .empty(empty), .full(full), .count(count),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Advance the model with the currently driven inputs, then step one clock and settle.
    task automatic tick();
        bit rq, wr, rd, nc;
        rq = rN | rE | rW | rS | rL;
        wr = DRTS && m_cts && (m_q.size() < DEPTH);
        rd = rq && (m_q.size() > 0);
        m_wrote = 0;
        if (rst) begin
            m_q.delete();
            m_cts = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (DRTS && m_cts && m_q.size() == DEPTH) m_ovf = 1;
            if (rq && m_q.size() == 0) m_unf = 1;
            nc = DRTS && !m_cts && (m_q.size() < DEPTH);
            if (rd) void'(m_q.pop_front());
            if (wr) begin m_q.push_back(RX); m_wrote = 1; end
            m_cts = nc;
        end
        @(posedge clk);
        #1;
    endtask

    // Upstream side: hold RTS until a CTS is seen, keep it for the capture edge, then drop it.
    task automatic send_flit(input logic [DW-1:0] d, input bit pop_at_capture);
        int n;
        n = 0;
        RX = d; DRTS = 1'b1;
        while (CTS !== 1'b1 && n < 20) begin tick(); n++; end
        if (CTS !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout CTS=%b after %0d cycles, required 1", CTS, n);
        end
        rL = pop_at_capture;
        tick();
        rL = 1'b0; DRTS = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; DRTS = 1'b1; RX = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (CTS !== 1'b0) begin errors++; $display("FAIL reset_cts got=%b exp=0", CTS); end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
            checks++; if (Data_out !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", Data_out); end
            checks++; if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin errors++; $display("FAIL reset_errs got=%b%b exp=00", err_overflow, err_underflow); end
        end
        rst = 1'b0;
        tick();
        checks++; if (CTS !== 1'b1) begin errors++; $display("FAIL reset_first_cts got=%b exp=1", CTS); end
        DRTS = 1'b0;
        tick();
        checks++; if (count !== 3'd0 || CTS !== 1'b0) begin errors++; $display("FAIL reset_idle count=%0d cts=%b exp 0/0", count, CTS); end
    endtask

    task automatic test_single();
        send_flit(32'hA5A5_0001, 1'b0);
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (Data_out !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data got=%h exp=a5a50001", Data_out); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", empty); end
        rE = 1'b1; tick(); rE = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    endtask

    task automatic test_fill_stall();
        int pulses;
        bit seen;
        logic [DW-1:0] nxt;
        pulses = 0; seen = 0; nxt = 1;
        RX = nxt; DRTS = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (m_wrote) begin nxt++; RX = nxt; end
            if (CTS === 1'b1) pulses++;
            checks++; if (CTS !== m_cts) begin errors++; $display("FAIL fill_cts cycle=%0d got=%b exp=%b", c, CTS, m_cts); end
            if (full === 1'b1) begin
                checks++; if (CTS !== 1'b0) begin errors++; $display("FAIL fill_cts_while_full got=%b exp=0", CTS); end
            end
        end
        checks++; if (pulses != 4) begin errors++; $display("FAIL fill_pulses got=%0d exp=4", pulses); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (Data_out !== 32'd1) begin errors++; $display("FAIL fill_head got=%0d exp=1", Data_out); end
        rN = 1'b1; tick(); rN = 1'b0;
        checks++; if (Data_out !== 32'd2) begin errors++; $display("FAIL fill_pop_head got=%0d exp=2", Data_out); end
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            if (CTS === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL fill_resume_cts got=0 exp=1 within 2 cycles"); end
        tick();
        DRTS = 1'b0;
        checks++; if (count !== 3'd4 || m_q.size() != 4) begin errors++; $display("FAIL fill_flit5_count got=%0d exp=4", count); end
        rN = 1'b1; tick(); tick(); rN = 1'b0;
        checks++; if (Data_out !== 32'd4 || count !== 3'd2) begin errors++; $display("FAIL fill_drain data=%0d count=%0d exp 4/2", Data_out, count); end
    endtask

    task automatic test_simul_write_pop();
        send_flit(32'd6, 1'b1);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count got=%0d exp=2", count); end
        checks++; if (Data_out !== 32'd5) begin errors++; $display("FAIL simul_head got=%0d exp=5", Data_out); end
        send_flit(32'd7, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL simul_refill got=%0d exp=3", count); end
    endtask

    task automatic test_multi_underflow();
        rN = 1'b1; rS = 1'b1; tick(); rN = 1'b0; rS = 1'b0;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL multi_count got=%0d exp=2", count); end
        checks++; if (Data_out !== 32'd6) begin errors++; $display("FAIL multi_head got=%0d exp=6", Data_out); end
        rE = 1'b1; tick(); tick(); rE = 1'b0;
        checks++; if (empty !== 1'b1 || err_underflow !== 1'b0) begin errors++; $display("FAIL multi_drain empty=%b unf=%b exp 1/0", empty, err_underflow); end
        rW = 1'b1; tick(); rW = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL underflow_count got=%0d exp=0", count); end
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag got=%b exp=1", err_underflow); end
        tick(); tick(); tick();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", err_underflow); end
        send_flit(32'd9, 1'b0);
        checks++; if (Data_out !== 32'd9 || count !== 3'd1) begin errors++; $display("FAIL underflow_ptrs data=%0d count=%0d exp 9/1", Data_out, count); end
        rE = 1'b1; tick(); rE = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", err_underflow); end
    endtask

    task automatic test_wrap();
        int got, cyc, nxt, maxc;
        got = 0; cyc = 0; nxt = 1; maxc = 0;
        RX = 32'd1; DRTS = 1'b1;
        while (got < 12 && cyc < 400) begin
            bit do_pop;
            int lane;
            do_pop = (cyc % 2 == 1) && (m_q.size() > 0);
            lane = $urandom_range(0, 4);
            if (do_pop) begin
                checks++; if (Data_out !== DW'(got + 1)) begin errors++; $display("FAIL wrap_order got=%0d exp=%0d", Data_out, got + 1); end
                got++;
                rN = (lane == 0); rE = (lane == 1); rW = (lane == 2); rS = (lane == 3); rL = (lane == 4);
            end
            tick();
            rN = 1'b0; rE = 1'b0; rW = 1'b0; rS = 1'b0; rL = 1'b0;
            cyc++;
            if (m_wrote) begin
                nxt++;
                if (nxt > 12) DRTS = 1'b0; else RX = DW'(nxt);
            end
            if (int'(count) > maxc) maxc = int'(count);
        end
        DRTS = 1'b0;
        checks++; if (got != 12) begin errors++; $display("FAIL wrap_received got=%0d exp=12", got); end
        checks++; if (maxc > 4) begin errors++; $display("FAIL wrap_maxcount got=%0d exp<=4", maxc); end
        checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin errors++; $display("FAIL wrap_errs got=%b%b exp=00", err_overflow, err_underflow); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            DRTS = ($urandom_range(0, 3) != 0);
            RX   = $urandom;
            rN = ($urandom_range(0, 6) == 0); rE = ($urandom_range(0, 6) == 0);
            rW = ($urandom_range(0, 6) == 0); rS = ($urandom_range(0, 6) == 0);
            rL = ($urandom_range(0, 6) == 0);
            tick();
            checks++; if (CTS !== m_cts) begin errors++; $display("FAIL rand_cts c=%0d got=%b exp=%b", c, CTS, m_cts); end
            checks++; if (count !== 3'(m_q.size())) begin errors++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, m_q.size()); end
            checks++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rand_flags c=%0d empty=%b full=%b size=%0d", c, empty, full, m_q.size()); end
            checks++; if (err_underflow !== m_unf || err_overflow !== m_ovf) begin errors++; $display("FAIL rand_errs c=%0d got=%b%b exp=%b%b", c, err_overflow, err_underflow, m_ovf, m_unf); end
            if (m_q.size() > 0) begin
                checks++; if (Data_out !== m_q[0]) begin errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, Data_out, m_q[0]); end
            end
        end
        DRTS = 1'b0; rN = 1'b0; rE = 1'b0; rW = 1'b0; rS = 1'b0; rL = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_simul_write_pop();
        test_multi_underflow();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
